if_fetch_controller: RTL and testbench

- Sequences the instruction memory for the IF stage.
- Owns the PC register and issues one word-fetch request at a time over a req/ready handshake.
- Applies branch redirects and decode stalls.
- Delivers instn/pc/nextpc to the IF/ID register through a 1-deep output register plus a 1-entry skid buffer.
- Raises a sticky error if memory never answers.

---
 rtl/if_fetch_controller.sv | 142 ++++++++++++++
 tb/tb_if_fetch_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_controller.sv
// IF-stage fetch sequencer: owns the PC, issues one instruction-memory request at a time,
// and hands instn/pc/nextpc to IF/ID through an output register backed by a 1-entry skid.
module if_fetch_controller #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ADDR_W   = 10,
   parameter int          MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [31:0]       branch_target,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       if_instn,
   output logic [31:0]       if_pc,
   output logic [31:0]       if_nextpc,
   output logic              if_valid,
   output logic              fetch_err
);

   localparam int WCW = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {IDLE, REQ_WAIT, ERR} state_t;

   state_t         state;
   logic [31:0]    pc;
   logic [WCW-1:0] wait_cnt;
   logic           drop;
   logic           skid_valid;
   logic [31:0]    skid_instn;
   logic [31:0]    skid_pc;

   logic        accept;
   logic        take;
   logic        consume;
   logic        br;
   logic [31:0] br_pc;
   logic [31:0] pc_inc;

   assign accept  = (state == REQ_WAIT) && imem_req && imem_ready;
   assign take    = accept && !drop;
   assign consume = if_valid && !stall;
   assign br      = branch_taken && (state != ERR);
   assign br_pc   = branch_target & ~32'h3;
   assign pc_inc  = pc + 32'd4;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         imem_req   <= 1'b0;
         imem_addr  <= '0;
         wait_cnt   <= '0;
         drop       <= 1'b0;
         skid_valid <= 1'b0;
         skid_instn <= '0;
         skid_pc    <= '0;
         if_instn   <= '0;
         if_pc      <= '0;
         if_nextpc  <= '0;
         if_valid   <= 1'b0;
         fetch_err  <= 1'b0;
      end else begin
         // Delivery path; the FSM below runs after it so entering ERR clears valid last.
         if (state == ERR) begin
            if_valid   <= 1'b0;
            skid_valid <= 1'b0;
         end else if (br) begin
            pc         <= br_pc;
            if_valid   <= 1'b0;
            skid_valid <= 1'b0;
            if (state == REQ_WAIT && !accept)
               drop <= 1'b1;
         end else begin
            if (take)
               pc <= pc_inc;
            if (consume) begin
               if (skid_valid) begin
                  if_instn   <= skid_instn;
                  if_pc      <= skid_pc;
                  if_nextpc  <= skid_pc + 32'd4;
                  skid_valid <= 1'b0;
               end else if (take) begin
                  if_instn  <= imem_rdata;
                  if_pc     <= pc;
                  if_nextpc <= pc_inc;
               end else begin
                  if_valid <= 1'b0;
               end
            end else if (take) begin
               if (!if_valid) begin
                  if_instn  <= imem_rdata;
                  if_pc     <= pc;
                  if_nextpc <= pc_inc;
                  if_valid  <= 1'b1;
               end else begin
                  skid_instn <= imem_rdata;
                  skid_pc    <= pc;
                  skid_valid <= 1'b1;
               end
            end
         end

         case (state)
            IDLE: begin
               // A full skid means decode is backed up; hold off the next fetch.
               if (!skid_valid) begin
                  state     <= REQ_WAIT;
                  imem_req  <= 1'b1;
                  imem_addr <= br ? br_pc[ADDR_W+1:2] : pc[ADDR_W+1:2];
                  wait_cnt  <= '0;
               end
            end
            REQ_WAIT: begin
               if (accept) begin
                  state    <= IDLE;
                  imem_req <= 1'b0;
                  drop     <= 1'b0;
                  wait_cnt <= '0;
               end else if (wait_cnt == WCW'(MAX_WAIT - 1)) begin
                  state      <= ERR;
                  imem_req   <= 1'b0;
                  fetch_err  <= 1'b1;
                  if_valid   <= 1'b0;
                  skid_valid <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ERR: begin
               imem_req  <= 1'b0;
               fetch_err <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_controller.sv
// Directed bench for if_fetch_controller: inputs driven and outputs sampled on the falling edge.
module tb_if_fetch_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [9:0]  imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] if_instn;
   logic [31:0] if_pc;
   logic [31:0] if_nextpc;
   logic        if_valid;
   logic        fetch_err;

   int checks = 0;
   int errors = 0;

   if_fetch_controller #(.RESET_PC(32'h0), .ADDR_W(10), .MAX_WAIT(15)) dut (
      .clk(clk), .reset(reset), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .if_instn(if_instn), .if_pc(if_pc), .if_nextpc(if_nextpc),
      .if_valid(if_valid), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_req(input int max_cycles);
      int n;
      n = 0;
      while (imem_req !== 1'b1 && n < max_cycles) begin
         tick();
         n++;
      end
      check("req_within_bound", 32'(imem_req), 32'd1);
   endtask

   // Memory answers lat cycles after the request became visible.
   task automatic respond(input int lat, input logic [31:0] data);
      for (int i = 1; i < lat; i++) tick();
      imem_ready = 1'b1;
      imem_rdata = data;
      tick();
      imem_ready = 1'b0;
      imem_rdata = 32'h0;
   endtask

   initial begin
      reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
      imem_ready = 1'b0; imem_rdata = 32'h0;
      tick(); tick(); tick();
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_addr", 32'(imem_addr), 32'd0);
      check("rst_valid", 32'(if_valid), 32'd0);
      check("rst_pc", if_pc, 32'h0);
      check("rst_err", 32'(fetch_err), 32'd0);

      // Straight-line fetch, 2-cycle memory, no stall
      reset = 1'b1;
      wait_req(8);
      check("f0_addr", 32'(imem_addr), 32'd0);
      respond(2, 32'hA000_0000);
      check("f0_valid", 32'(if_valid), 32'd1);
      check("f0_instn", if_instn, 32'hA000_0000);
      check("f0_pc", if_pc, 32'h0);
      check("f0_npc", if_nextpc, 32'h4);
      tick();
      check("f0_pulse", 32'(if_valid), 32'd0);
      check("f1_addr", 32'(imem_addr), 32'd1);
      respond(2, 32'hA000_0001);
      check("f1_pc", if_pc, 32'h4);
      check("f1_npc", if_nextpc, 32'h8);

      // Stall while the next word returns: it lands in the skid
      stall = 1'b1;
      tick();
      check("f2_addr", 32'(imem_addr), 32'd2);
      check("stall_hold_pc", if_pc, 32'h4);
      respond(2, 32'hA000_0002);
      check("stall_hold_instn", if_instn, 32'hA000_0001);
      check("stall_hold_valid", 32'(if_valid), 32'd1);
      tick();
      check("stall_no_req", 32'(imem_req), 32'd0);
      tick();
      check("stall_no_req2", 32'(imem_req), 32'd0);
      check("stall_hold_pc2", if_pc, 32'h4);
      stall = 1'b0;
      tick();
      check("skid_pc", if_pc, 32'h8);
      check("skid_npc", if_nextpc, 32'hC);
      check("skid_instn", if_instn, 32'hA000_0002);
      check("skid_no_req", 32'(imem_req), 32'd0);
      tick();
      check("skid_drain_valid", 32'(if_valid), 32'd0);
      check("f3_addr", 32'(imem_addr), 32'd3);
      respond(2, 32'hA000_0003);
      check("f3_pc", if_pc, 32'hC);

      // Branch while the request to 0x10 is outstanding
      tick();
      check("f4_addr", 32'(imem_addr), 32'd4);
      branch_taken = 1'b1; branch_target = 32'h0000_0103;
      tick();
      branch_taken = 1'b0;
      check("br_req_stable", 32'(imem_addr), 32'd4);
      check("br_flush_valid", 32'(if_valid), 32'd0);
      imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_ready = 1'b0; imem_rdata = 32'h0;
      check("drop_no_valid", 32'(if_valid), 32'd0);
      check("drop_req_low", 32'(imem_req), 32'd0);
      tick();
      check("br_tgt_addr", 32'(imem_addr), 32'h40);
      check("br_tgt_req", 32'(imem_req), 32'd1);
      respond(2, 32'hB000_0100);
      check("br_tgt_pc", if_pc, 32'h100);
      check("br_tgt_npc", if_nextpc, 32'h104);
      check("br_tgt_instn", if_instn, 32'hB000_0100);

      // Branch on the same edge as imem_ready
      tick();
      check("f5_addr", 32'(imem_addr), 32'h41);
      imem_ready = 1'b1; imem_rdata = 32'hBAD0_BAD0;
      branch_taken = 1'b1; branch_target = 32'h0000_0200;
      tick();
      imem_ready = 1'b0; imem_rdata = 32'h0; branch_taken = 1'b0;
      check("brrdy_no_valid", 32'(if_valid), 32'd0);
      check("brrdy_req_low", 32'(imem_req), 32'd0);
      tick();
      check("brrdy_tgt_addr", 32'(imem_addr), 32'h80);
      respond(2, 32'hC000_0200);
      check("brrdy_no_drop_valid", 32'(if_valid), 32'd1);
      check("brrdy_pc", if_pc, 32'h200);
      check("brrdy_instn", if_instn, 32'hC000_0200);

      // Reset mid-wait with if_valid held by stall
      stall = 1'b1;
      tick();
      check("mid_req", 32'(imem_req), 32'd1);
      check("mid_valid", 32'(if_valid), 32'd1);
      tick();
      reset = 1'b0;
      tick();
      check("mr_req", 32'(imem_req), 32'd0);
      check("mr_valid", 32'(if_valid), 32'd0);
      check("mr_instn", if_instn, 32'h0);
      check("mr_pc", if_pc, 32'h0);
      check("mr_npc", if_nextpc, 32'h0);
      reset = 1'b1; stall = 1'b0;
      tick();
      check("mr_first_req", 32'(imem_req), 32'd1);
      check("mr_first_addr", 32'(imem_addr), 32'd0);

      // Timeout: memory never answers
      for (int i = 0; i < 14; i++) tick();
      check("to_pre_err", 32'(fetch_err), 32'd0);
      check("to_pre_req", 32'(imem_req), 32'd1);
      tick();
      check("to_err", 32'(fetch_err), 32'd1);
      check("to_req_low", 32'(imem_req), 32'd0);
      check("to_valid", 32'(if_valid), 32'd0);
      branch_taken = 1'b1; branch_target = 32'h0000_0300;
      tick();
      branch_taken = 1'b0;
      tick();
      check("err_sticky", 32'(fetch_err), 32'd1);
      check("err_br_ignored", 32'(imem_req), 32'd0);
      reset = 1'b0;
      tick();
      check("err_cleared", 32'(fetch_err), 32'd0);
      reset = 1'b1;
      tick();
      check("post_err_addr", 32'(imem_addr), 32'd0);

      // PC wrap at the top of the address space
      branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
      tick();
      branch_taken = 1'b0;
      imem_ready = 1'b1; imem_rdata = 32'h1111_1111;
      tick();
      imem_ready = 1'b0; imem_rdata = 32'h0;
      tick();
      check("wrap_addr", 32'(imem_addr), 32'h3FF);
      respond(1, 32'hE000_FFFC);
      check("wrap_pc", if_pc, 32'hFFFF_FFFC);
      check("wrap_npc", if_nextpc, 32'h0);
      tick();
      check("wrap_next_addr", 32'(imem_addr), 32'd0);
      check("wrap_next_req", 32'(imem_req), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

endmodule
